// File: rtl/i2s_tx_10xe_axi4_lite_regs.sv
// AXI4-Lite register block for the I2S transmitter control port.
// Independent write/read FSMs, W1C interrupt status and a registered, masked irq.
module i2s_tx_10xe_axi4_lite_regs #(
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] CORE_CFG     = 32'h0000_0001,
  parameter logic [7:0]  SCLK_DIV_RST = 8'h04
) (
  input  logic        s_axi_ctrl_aclk,
  input  logic        s_axi_ctrl_aresetn,
  input  logic        s_axi_ctrl_awvalid,
  output logic        s_axi_ctrl_awready,
  input  logic [7:0]  s_axi_ctrl_awaddr,
  input  logic        s_axi_ctrl_wvalid,
  output logic        s_axi_ctrl_wready,
  input  logic [31:0] s_axi_ctrl_wdata,
  output logic        s_axi_ctrl_bvalid,
  input  logic        s_axi_ctrl_bready,
  output logic [1:0]  s_axi_ctrl_bresp,
  input  logic        s_axi_ctrl_arvalid,
  output logic        s_axi_ctrl_arready,
  input  logic [7:0]  s_axi_ctrl_araddr,
  output logic        s_axi_ctrl_rvalid,
  input  logic        s_axi_ctrl_rready,
  output logic [1:0]  s_axi_ctrl_rresp,
  output logic [31:0] s_axi_ctrl_rdata,
  input  logic        evt_underflow,
  input  logic        evt_block_done,
  output logic        tx_enable,
  output logic        tx_validity,
  output logic [7:0]  sclk_div,
  output logic        irq
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // valid, once raised, is held with stable payload until that edge.
  localparam logic [5:0] IDX_VERSION  = 6'h00;
  localparam logic [5:0] IDX_CONFIG   = 6'h01;
  localparam logic [5:0] IDX_CONTROL  = 6'h02;
  localparam logic [5:0] IDX_VALIDITY = 6'h03;
  localparam logic [5:0] IDX_IRQ_EN   = 6'h04;
  localparam logic [5:0] IDX_IRQ_STAT = 6'h05;
  localparam logic [5:0] IDX_TIMING   = 6'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic       aw_got, w_got;
  logic [5:0] aw_idx_q;
  logic [8:0] w_data_q;   // {wdata[31], wdata[7:0]}: the only bits any register keeps
  logic       wr_en;

  logic       ctrl_q, valid_q, irq_glb_q;
  logic [1:0] irq_src_en_q, irq_stat_q, stat_clr;
  logic [7:0] timing_q;

  logic [31:0] rd_mux;
  logic        rd_ok;

  logic unused_ok;
  assign unused_ok = ^{s_axi_ctrl_wdata[30:8], s_axi_ctrl_awaddr[1:0], s_axi_ctrl_araddr[1:0]};

  function automatic logic idx_mapped(input logic [5:0] idx);
    case (idx)
      IDX_VERSION, IDX_CONFIG, IDX_CONTROL, IDX_VALIDITY,
      IDX_IRQ_EN, IDX_IRQ_STAT, IDX_TIMING: idx_mapped = 1'b1;
      default:                              idx_mapped = 1'b0;
    endcase
  endfunction

  assign wr_en    = (w_state == W_IDLE) && aw_got && w_got;
  assign stat_clr = (wr_en && aw_idx_q == IDX_IRQ_STAT) ? w_data_q[1:0] : 2'b00;

  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      w_state            <= W_IDLE;
      s_axi_ctrl_awready <= 1'b0;
      s_axi_ctrl_wready  <= 1'b0;
      s_axi_ctrl_bvalid  <= 1'b0;
      s_axi_ctrl_bresp   <= RESP_OKAY;
      aw_got             <= 1'b0;
      w_got              <= 1'b0;
      aw_idx_q           <= 6'h00;
      w_data_q           <= 9'h000;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_got && w_got) begin
            s_axi_ctrl_bvalid <= 1'b1;
            s_axi_ctrl_bresp  <= idx_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
            w_state           <= W_RESP;
          end else begin
            // Each channel closes on its own once its beat is held.
            if (s_axi_ctrl_awvalid && s_axi_ctrl_awready) begin
              aw_idx_q           <= s_axi_ctrl_awaddr[7:2];
              aw_got             <= 1'b1;
              s_axi_ctrl_awready <= 1'b0;
            end else if (!aw_got) begin
              s_axi_ctrl_awready <= 1'b1;
            end
            if (s_axi_ctrl_wvalid && s_axi_ctrl_wready) begin
              w_data_q          <= {s_axi_ctrl_wdata[31], s_axi_ctrl_wdata[7:0]};
              w_got             <= 1'b1;
              s_axi_ctrl_wready <= 1'b0;
            end else if (!w_got) begin
              s_axi_ctrl_wready <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_ctrl_bready) begin
            s_axi_ctrl_bvalid  <= 1'b0;
            aw_got             <= 1'b0;
            w_got              <= 1'b0;
            s_axi_ctrl_awready <= 1'b1;
            s_axi_ctrl_wready  <= 1'b1;
            w_state            <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      ctrl_q       <= 1'b0;
      valid_q      <= 1'b0;
      irq_glb_q    <= 1'b0;
      irq_src_en_q <= 2'b00;
      irq_stat_q   <= 2'b00;
      timing_q     <= SCLK_DIV_RST;
      irq          <= 1'b0;
    end else begin
      if (wr_en) begin
        case (aw_idx_q)
          IDX_CONTROL:  ctrl_q  <= w_data_q[0];
          IDX_VALIDITY: valid_q <= w_data_q[0];
          IDX_IRQ_EN: begin
            irq_glb_q    <= w_data_q[8];
            irq_src_en_q <= w_data_q[1:0];
          end
          IDX_TIMING:   timing_q <= w_data_q[7:0];
          default: ;
        endcase
      end
      // A new event in the clearing cycle wins over the W1C.
      irq_stat_q <= (irq_stat_q & ~stat_clr) | {evt_block_done, evt_underflow};
      irq        <= irq_glb_q & |(irq_stat_q & irq_src_en_q);
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    rd_ok  = 1'b1;
    case (s_axi_ctrl_araddr[7:2])
      IDX_VERSION:  rd_mux = VERSION;
      IDX_CONFIG:   rd_mux = CORE_CFG;
      IDX_CONTROL:  rd_mux = {31'h0, ctrl_q};
      IDX_VALIDITY: rd_mux = {31'h0, valid_q};
      IDX_IRQ_EN:   rd_mux = {irq_glb_q, 29'h0, irq_src_en_q};
      IDX_IRQ_STAT: rd_mux = {30'h0, irq_stat_q};
      IDX_TIMING:   rd_mux = {24'h0, timing_q};
      default:      rd_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      r_state            <= R_IDLE;
      s_axi_ctrl_arready <= 1'b0;
      s_axi_ctrl_rvalid  <= 1'b0;
      s_axi_ctrl_rdata   <= 32'h0;
      s_axi_ctrl_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_ctrl_arvalid && s_axi_ctrl_arready) begin
            s_axi_ctrl_rdata   <= rd_mux;
            s_axi_ctrl_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_ctrl_rvalid  <= 1'b1;
            s_axi_ctrl_arready <= 1'b0;
            r_state            <= R_RESP;
          end else begin
            s_axi_ctrl_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi_ctrl_rready) begin
            s_axi_ctrl_rvalid  <= 1'b0;
            s_axi_ctrl_arready <= 1'b1;
            r_state            <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign tx_enable   = ctrl_q;
  assign tx_validity = valid_q;
  assign sclk_div    = timing_q;

endmodule
